// File: rtl/ifft_butterfly_7.sv
// ifft_butterfly_7: pipelined radix-2 DIF butterfly for the inverse transform.
//   y0 = a + b, y1 = (a - b) * e^{+j*2*pi*k/16}, three register stages,
//   valid/ready handshake on both sides.
// Optional build macro IFFT_SCALE_EN: halve both outputs (floor) for bounded gain.
module ifft_butterfly_7 #(
    parameter int DW      = 12,
    parameter int TW_FRAC = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    index,
    input  logic [DW-1:0] a_real,
    input  logic [DW-1:0] a_img,
    input  logic [DW-1:0] b_real,
    input  logic [DW-1:0] b_img,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] y0_real,
    output logic [DW-1:0] y0_img,
    output logic [DW-1:0] y1_real,
    output logic [DW-1:0] y1_img
);

    localparam int TWW = TW_FRAC + 2;  // signed Q1.TW_FRAC, holds +/-1.0
    localparam int SW  = DW + 1;       // sum/difference width
    localparam int PW  = 2 * DW + 2;   // full product/accumulate width

    logic signed [TWW-1:0] cos_lut, sin_lut;

    logic                  v1, v2, v3;
    logic                  adv1, adv2, adv3;

    logic signed [DW-1:0]  s1_ar, s1_ai, s1_br, s1_bi;
    logic signed [TWW-1:0] s1_cos, s1_sin;

    logic signed [SW-1:0]  s2_sum_re, s2_sum_im, s2_dif_re, s2_dif_im;
    logic signed [TWW-1:0] s2_cos, s2_sin;

    logic signed [PW-1:0]  p_re, p_im;
    logic [DW-1:0]         y0r_n, y0i_n, y1r_n, y1i_n;
    logic                  unused_bits;

    // Inverse twiddle ROM: W = cos + j*sin for k = 0..7
    always_comb begin
        cos_lut = TWW'(1024);
        sin_lut = TWW'(0);
        case (index)
            3'd0: begin cos_lut = TWW'(1024);  sin_lut = TWW'(0);    end
            3'd1: begin cos_lut = TWW'(946);   sin_lut = TWW'(392);  end
            3'd2: begin cos_lut = TWW'(724);   sin_lut = TWW'(724);  end
            3'd3: begin cos_lut = TWW'(392);   sin_lut = TWW'(946);  end
            3'd4: begin cos_lut = TWW'(0);     sin_lut = TWW'(1024); end
            3'd5: begin cos_lut = TWW'(-392);  sin_lut = TWW'(946);  end
            3'd6: begin cos_lut = TWW'(-724);  sin_lut = TWW'(724);  end
            default: begin cos_lut = TWW'(-946); sin_lut = TWW'(392); end
        endcase
    end

    // Stage advance chain: a stage moves when empty or when the next one moves
    always_comb begin
        adv3     = !v3 || out_ready;
        adv2     = !v2 || adv3;
        adv1     = !v1 || adv2;
        in_ready = adv1;
    end

    // S1: capture inputs and twiddle on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            s1_ar  <= '0;
            s1_ai  <= '0;
            s1_br  <= '0;
            s1_bi  <= '0;
            s1_cos <= '0;
            s1_sin <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_ar  <= a_real;
                s1_ai  <= a_img;
                s1_br  <= b_real;
                s1_bi  <= b_img;
                s1_cos <= cos_lut;
                s1_sin <= sin_lut;
            end
        end
    end

    // S2: sign-extended sum and difference, twiddle carried alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2        <= 1'b0;
            s2_sum_re <= '0;
            s2_sum_im <= '0;
            s2_dif_re <= '0;
            s2_dif_im <= '0;
            s2_cos    <= '0;
            s2_sin    <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                s2_sum_re <= SW'(s1_ar) + SW'(s1_br);
                s2_sum_im <= SW'(s1_ai) + SW'(s1_bi);
                s2_dif_re <= SW'(s1_ar) - SW'(s1_br);
                s2_dif_im <= SW'(s1_ai) - SW'(s1_bi);
                s2_cos    <= s1_cos;
                s2_sin    <= s1_sin;
            end
        end
    end

    // Full-width complex multiply and output scaling (bit slices implement floor shifts)
    always_comb begin
        p_re = PW'(s2_dif_re) * PW'(s2_cos) - PW'(s2_dif_im) * PW'(s2_sin);
        p_im = PW'(s2_dif_re) * PW'(s2_sin) + PW'(s2_dif_im) * PW'(s2_cos);
`ifdef IFFT_SCALE_EN
        y0r_n = s2_sum_re[DW:1];
        y0i_n = s2_sum_im[DW:1];
        y1r_n = p_re[TW_FRAC+DW:TW_FRAC+1];
        y1i_n = p_im[TW_FRAC+DW:TW_FRAC+1];
`else
        y0r_n = s2_sum_re[DW-1:0];
        y0i_n = s2_sum_im[DW-1:0];
        y1r_n = p_re[TW_FRAC+DW-1:TW_FRAC];
        y1i_n = p_im[TW_FRAC+DW-1:TW_FRAC];
`endif
        unused_bits = ^{p_re, p_im, s2_sum_re, s2_sum_im};
    end

    // S3: output registers, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3      <= 1'b0;
            y0_real <= '0;
            y0_img  <= '0;
            y1_real <= '0;
            y1_img  <= '0;
        end else if (adv3) begin
            v3 <= v2;
            if (v2) begin
                y0_real <= y0r_n;
                y0_img  <= y0i_n;
                y1_real <= y1r_n;
                y1_img  <= y1i_n;
            end
        end
    end

    assign out_valid = v3;

endmodule

// File: tb/tb_ifft_butterfly_7.sv
// Bench for ifft_butterfly_7: directed vectors with literal expectations,
// plus a queue-based arithmetic model checked every cycle by one monitor.
module tb_ifft_butterfly_7;

    localparam int DW      = 12;
    localparam int TW_FRAC = 10;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           index;
    logic signed [DW-1:0] a_real, a_img, b_real, b_img;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] y0_real, y0_img, y1_real, y1_img;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int y0r;
        int y0i;
        int y1r;
        int y1i;
    } exp_t;

    exp_t q[$];

    int cos_t[8] = '{1024, 946, 724, 392, 0, -392, -724, -946};
    int sin_t[8] = '{0, 392, 724, 946, 1024, 946, 724, 392};

    ifft_butterfly_7 #(.DW(DW), .TW_FRAC(TW_FRAC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .index     (index),
        .a_real    (a_real),
        .a_img     (a_img),
        .b_real    (b_real),
        .b_img     (b_img),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0_real   (y0_real),
        .y0_img    (y0_img),
        .y1_real   (y1_real),
        .y1_img    (y1_img)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int wrap(input int x);
        logic signed [DW-1:0] t;
        t = x[DW-1:0];
        return int'(t);
    endfunction

    // Butterfly in plain integer arithmetic: complex sum, complex product, floor shift, wrap
    function automatic exp_t model(input int ar, input int ai, input int br, input int bi, input int k);
        exp_t r;
        int sr, si, dr, di, pr, pim;
        sr  = ar + br;
        si  = ai + bi;
        dr  = ar - br;
        di  = ai - bi;
        pr  = dr * cos_t[k] - di * sin_t[k];
        pim = dr * sin_t[k] + di * cos_t[k];
`ifdef IFFT_SCALE_EN
        r.y0r = wrap(sr >>> 1);
        r.y0i = wrap(si >>> 1);
        r.y1r = wrap(pr >>> (TW_FRAC + 1));
        r.y1i = wrap(pim >>> (TW_FRAC + 1));
`else
        r.y0r = wrap(sr);
        r.y0i = wrap(si);
        r.y1r = wrap(pr >>> TW_FRAC);
        r.y1i = wrap(pim >>> TW_FRAC);
`endif
        return r;
    endfunction

    // Single compare process: reset state, in_ready vs occupancy, outputs vs model queue
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            q.delete();
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_y0_real", int'(y0_real), 0);
            check("rst_y0_img", int'(y0_img), 0);
            check("rst_y1_real", int'(y1_real), 0);
            check("rst_y1_img", int'(y1_img), 0);
        end else begin
            check("in_ready_vs_occupancy", int'(in_ready),
                  (q.size() == 3 && !out_ready) ? 0 : 1);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_output_count", 1, 0);
                end else begin
                    check("model_y0_real", int'(y0_real), q[0].y0r);
                    check("model_y0_img", int'(y0_img), q[0].y0i);
                    check("model_y1_real", int'(y1_real), q[0].y1r);
                    check("model_y1_img", int'(y1_img), q[0].y1i);
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(int'(a_real), int'(a_img), int'(b_real), int'(b_img), int'(index)));
        end
    end

    task automatic drive(input int ar, input int ai, input int br, input int bi, input int k);
        a_real = DW'(ar);
        a_img  = DW'(ai);
        b_real = DW'(br);
        b_img  = DW'(bi);
        index  = 3'(k);
    endtask

    // One isolated transaction: checks exact 3-cycle latency and literal results
    task automatic send_one(input string nm, input int ar, input int ai, input int br, input int bi,
                            input int k, input int u0r, input int u0i, input int u1r, input int u1i,
                            input int s0r, input int s0i, input int s1r, input int s1i);
        int e0r, e0i, e1r, e1i;
`ifdef IFFT_SCALE_EN
        e0r = s0r; e0i = s0i; e1r = s1r; e1i = s1i;
`else
        e0r = u0r; e0i = u0i; e1r = u1r; e1i = u1i;
`endif
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(ar, ai, br, bi, k);
        #1;
        check({nm, "_in_ready"}, int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        check({nm, "_valid_c1"}, int'(out_valid), 0);
        @(negedge clk);
        #3;
        check({nm, "_valid_c2"}, int'(out_valid), 0);
        @(negedge clk);
        #3;
        check({nm, "_valid_c3"}, int'(out_valid), 1);
        check({nm, "_y0_real"}, int'(y0_real), e0r);
        check({nm, "_y0_img"}, int'(y0_img), e0i);
        check({nm, "_y1_real"}, int'(y1_real), e1r);
        check({nm, "_y1_img"}, int'(y1_img), e1i);
    endtask

    task automatic pin_model();
        exp_t r;
        r = model(0, 200, 0, -100, 1);
`ifdef IFFT_SCALE_EN
        check("pin_k1_y0i", r.y0i, 50);
        check("pin_k1_y1r", r.y1r, -58);
        check("pin_k1_y1i", r.y1i, 138);
`else
        check("pin_k1_y0i", r.y0i, 100);
        check("pin_k1_y1r", r.y1r, -115);
        check("pin_k1_y1i", r.y1i, 277);
`endif
        r = model(-3, 0, 0, 0, 0);
`ifdef IFFT_SCALE_EN
        check("pin_floor_y0r", r.y0r, -2);
        check("pin_floor_y1r", r.y1r, -2);
`else
        check("pin_floor_y0r", r.y0r, -3);
        check("pin_floor_y1r", r.y1r, -3);
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        pin_model();

        //       name      ar    ai   br   bi    k   unscaled y0r,y0i,y1r,y1i   scaled y0r,y0i,y1r,y1i
        send_one("basic",  100,  0,   50,  0,    0,  150, 0, 50, 0,           75, 0, 25, 0);
        send_one("rot_k4", 100,  0,   50,  0,    4,  150, 0, 0, 50,           75, 0, 0, 25);
        send_one("k2",     100,  0,   0,   0,    2,  100, 0, 70, 70,          50, 0, 35, 35);
        send_one("floor",  -3,   0,   0,   0,    0,  -3, 0, -3, 0,            -2, 0, -2, 0);
        send_one("imag_k1", 0,   200, 0,   -100, 1,  0, 100, -115, 277,       0, 50, -58, 138);
        send_one("wrap",   2047, 0,   1,   0,    0,  -2048, 0, 2046, 0,       1024, 0, 1023, 0);

        // Backpressure stream: out_ready cycles 1,0,0,1; in_valid drops now and then;
        // non-accepted cycles carry junk data and a changing index.
        begin
            int sent = 0;
            int t    = 0;
            while (sent < 8 && t < 200) begin
                @(negedge clk);
                out_ready = (t % 4 == 0) || (t % 4 == 3);
                in_valid  = (t % 5 != 2);
                #1;
                if (in_valid && in_ready) begin
                    drive(100 * sent - 350, 37 * sent, -60 * sent + 20, 500 - 90 * sent, sent);
                    sent++;
                end else begin
                    drive(1445, -1445, 777, -777, t);
                end
                t++;
            end
            check("bp_all_sent", sent, 8);
            @(negedge clk);
            in_valid = 1'b0;
            for (int w = 0; w < 60 && q.size() != 0; w++) begin
                @(negedge clk);
                out_ready = (t % 4 == 0) || (t % 4 == 3);
                t++;
            end
            check("bp_drained", q.size(), 0);
        end

        // Reset mid-stream with three pairs in flight and a fourth waiting
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            drive(10 * i + 5, -7 * i, 3 * i, 11, i + 3);
            @(negedge clk);
        end
        drive(999, 999, 999, 999, 5);
        #1;
        check("full_in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_imm_out_valid", int'(out_valid), 0);
        check("rst_imm_y0_real", int'(y0_real), 0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send_one("post_rst", 100, 0, 50, 0, 0, 150, 0, 50, 0, 75, 0, 25, 0);

        repeat (3) @(negedge clk);
        check("final_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ifft_butterfly_7.md
Name: ifft_butterfly_7

Overview:
- Pipelined radix-2 decimation-in-frequency butterfly for the inverse transform path, the counterpart of the forward FFT-7 butterfly.
- Computes sum = a+b and diff = (a−b)·conj-twiddle, using the inverse twiddle e^{+j2πk/16}.
- Valid/ready handshake on both sides, so an IFFT stage controller can stall it.
- Used to rebuild time-domain frames from processed spectra in the audio processing chain.

Parameters:
- DW, 12, sample width (signed two's complement, real and imaginary each)
- TW_FRAC, 10, twiddle fractional bits (Q1.10; 1.0 = 1024)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input pair valid
- in_ready  out  1  block can accept input this cycle
- index  in  3  twiddle index k, 0..7
- a_real, a_img  in  DW  upper input
- b_real, b_img  in  DW  lower input
- out_valid  out  1  output pair valid
- out_ready  in  1  downstream accepts output
- y0_real, y0_img  out  DW  sum output
- y1_real, y1_img  out  DW  twiddled difference output

Behaviour:
- Interface and reset:
  - One clock. Reset is asynchronous and active-low (rst_n).
  - All stage valid flags and all output registers reset to 0. out_valid=0 and y* = 0 during and after reset.
  - Reset asserted mid-operation discards all in-flight data. No partial output is produced afterwards.
- Twiddle ROM, combinational, indexed by k:
  - cos = 1024, 946, 724, 392, 0, −392, −724, −946
  - sin = 0, 392, 724, 946, 1024, 946, 724, 392
  - Inverse twiddle W = cos + j·sin.
- Pipeline, three register stages:
  - S1 registers a, b and the looked-up cos/sin.
  - S2 registers sum = a+b and diff = a−b, each DW+1 bits sign-extended.
  - S3 computes the products and registers the outputs.
    - pr = diff_re·cos − diff_im·sin
    - pi = diff_re·sin + diff_im·cos
    - Products and accumulation are kept at full width (2·DW+2 bits). No intermediate overflow.
- Output scaling, without the optional feature:
  - y0 = sum[DW−1:0]; overflow wraps.
  - y1 = (p >>> TW_FRAC)[DW−1:0]; arithmetic shift, truncation toward −∞, wraps.
- Latency is exactly 3 cycles from input handshake to out_valid with no backpressure. Throughput is 1 pair/cycle.
- Handshake:
  - An input is accepted when in_valid && in_ready.
  - An output is consumed when out_valid && out_ready.
  - Each stage n advances when it is empty or stage n+1 advances. S3 advances when out_ready=1 or S3 is empty.
  - in_ready = !v1 || advance1, a combinational chain from out_ready.
  - With out_ready=0 and all stages full, in_ready=0 and every register holds.
  - No data is dropped or duplicated.
  - y* are stable while out_valid=1 && out_ready=0.
  - in_valid may drop without the handshake completing. Inputs are sampled only on acceptance.
  - Simultaneous accept and consume with the pipe full sustains full rate.
- index is sampled together with a and b in S1. A change in index while stalled has no effect on held data.

Optional Feature:
- Macro: IFFT_SCALE_EN.
- Defined: every output is divided by 2 to keep IFFT gain bounded.
  - y0 = (sum >>> 1)[DW−1:0]
  - y1 = (p >>> (TW_FRAC+1))[DW−1:0]
  - Truncation toward −∞. No overflow is possible for y0.
- Undefined: unscaled behaviour as above. Latency and handshake are identical in both builds.

Test Plan:
- Basic, scale off:
  - a=(100,0), b=(50,0), k=0 -> after 3 cycles y0=(150,0), y1=(50,0).
  - Same vector with IFFT_SCALE_EN -> y0=(75,0), y1=(25,0).
- Rotation: a=(100,0), b=(50,0), k=4 -> y1=(0,50) unscaled; (0,25) scaled. Confirms +j (inverse) direction.
- Rounding, k=2, a=(100,0), b=(0,0):
  - y1=(70,70) unscaled; (35,35) scaled.
  - a=(−3,0), b=0, k=0 scaled -> y0=(−2,0), y1=(−2,0), floor truncation.
- Backpressure: stream 8 pairs with out_ready toggling 1,0,0,1… -> in_ready=0 once 3 stages are full; all 8 results appear in order with no loss or duplication; y* held while stalled.
- Reset mid-stream: assert rst_n=0 with 3 pairs in flight, then release -> out_valid=0 immediately and y*=0; first output after release corresponds to the first post-reset input, 3 cycles after acceptance.
- Wrap, scale off: a=(2047,0), b=(1,0), k=0 -> y0=(−2048,0) wraps, y1=(2046,0).
